multi_timekeeper: RTL

MULTI_TIMEKEEPER -- requirements
Module: multi_timekeeper

---
 rtl/tk_pkg.sv | 59 +++++
 rtl/tk_tmr_channel.sv | 69 ++++++
 rtl/multi_timekeeper.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tk_pkg.sv
// Shared definitions for the multi_timekeeper slice.
//   mode_e   : display/function select encodings
//   hms_t    : packed hours/minutes/seconds time value
//   hms_inc  : +1 s with 23:59:59 -> 00:00:00 wrap
//   hms_dec  : -1 s (caller guarantees a non-zero input)
package tk_pkg;

  typedef enum logic [1:0] {
    MODE_CLK24 = 2'b00,
    MODE_CLK12 = 2'b01,
    MODE_SW    = 2'b10,
    MODE_TMR   = 2'b11
  } mode_e;

  localparam logic [4:0] HOURS_MAX  = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;
  localparam logic [4:0] H12_MAX    = 5'd12;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  function automatic hms_t hms_inc(input hms_t t);
    hms_t r;
    r = t;
    if (t.s < MINSEC_MAX) begin
      r.s = t.s + 6'd1;
    end else begin
      r.s = '0;
      if (t.m < MINSEC_MAX) begin
        r.m = t.m + 6'd1;
      end else begin
        r.m = '0;
        r.h = (t.h < HOURS_MAX) ? t.h + 5'd1 : 5'd0;
      end
    end
    return r;
  endfunction

  function automatic hms_t hms_dec(input hms_t t);
    hms_t r;
    r = t;
    if (t.s != 6'd0) begin
      r.s = t.s - 6'd1;
    end else begin
      r.s = MINSEC_MAX;
      if (t.m != 6'd0) begin
        r.m = t.m - 6'd1;
      end else begin
        r.m = MINSEC_MAX;
        r.h = t.h - 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tk_tmr_channel.sv
// One countdown timer channel.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tick_i        : 1 s tick from the shared prescaler
//   load_i        : pulse, load set_i, stop, clear expired
//   run_tgl_i     : pulse, toggle run (ignored at 00:00:00), clear expired
//   set_i         : load value
//   time_o, running_o, expired_o : current channel state
// All control inputs are single-cycle pulses sampled on the rising edge;
// there is no back-pressure.
module tk_tmr_channel
  import tk_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic load_i,
  input  logic run_tgl_i,
  input  hms_t set_i,
  output hms_t time_o,
  output logic running_o,
  output logic expired_o
);

  hms_t time_q, time_d;
  logic run_q, run_d;
  logic exp_q, exp_d;

  always_comb begin
    time_d = time_q;
    run_d  = run_q;
    exp_d  = exp_q;
    if (load_i) begin
      time_d = set_i;
      run_d  = 1'b0;
      exp_d  = 1'b0;
    end else begin
      // The tick is applied under the run state held before this edge;
      // a toggle arriving in the same cycle acts on the post-tick result.
      if (tick_i && run_q) begin
        time_d = hms_dec(time_q);
        if (time_d == '0) begin
          run_d = 1'b0;
          exp_d = 1'b1;
        end
      end
      if (run_tgl_i) begin
        exp_d = 1'b0;
        if (time_d != '0) run_d = ~run_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q <= '0;
      run_q  <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      run_q  <= run_d;
      exp_q  <= exp_d;
    end
  end

  assign time_o    = time_q;
  assign running_o = run_q;
  assign expired_o = exp_q;

endmodule

// File: rtl/multi_timekeeper.sv
// Multi-function timekeeper: time of day (24 h / 12 h view), stopwatch with
// lap freeze, and NUM_TMR countdown timers sharing one 1 s prescaler.
//   clk, reset          : clock, asynchronous active-low reset
//   mode                : 00 clock24, 01 clock12, 10 stopwatch, 11 timer
//   tmr_sel             : timer channel addressed in mode 11
//   load, run_tgl, lap  : single-cycle command pulses
//   set_hours/mins/secs/pm : load values
//   hours_o..tick_o     : registered display, run state, expiry bits, tick
module multi_timekeeper
  import tk_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int NUM_TMR  = 2,
  localparam int SEL_W   = (NUM_TMR > 1) ? $clog2(NUM_TMR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   tmr_sel,
  input  logic               load,
  input  logic               run_tgl,
  input  logic               lap,
  input  logic [4:0]         set_hours,
  input  logic [5:0]         set_mins,
  input  logic [5:0]         set_secs,
  input  logic               set_pm,
  output logic [4:0]         hours_o,
  output logic [5:0]         mins_o,
  output logic [5:0]         secs_o,
  output logic               pm_o,
  output logic               running_o,
  output logic [NUM_TMR-1:0] expired_o,
  output logic               tick_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  mode_e mode_s;
  hms_t  set_hms;
  assign mode_s  = mode_e'(mode);
  assign set_hms = '{h: set_hours, m: set_mins, s: set_secs};

  // Prescaler
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Time-of-day load qualification; an invalid load is dropped entirely.
  logic       fields_ok, tod_load24, tod_load12;
  logic [4:0] h24_from12;
  assign fields_ok  = (set_mins <= MINSEC_MAX) && (set_secs <= MINSEC_MAX);
  assign tod_load24 = load && (mode_s == MODE_CLK24) && (set_hours <= HOURS_MAX) && fields_ok;
  assign tod_load12 = load && (mode_s == MODE_CLK12) && (set_hours != 5'd0) &&
                      (set_hours <= H12_MAX) && fields_ok;
  // 12 AM is hour 0, 12 PM is hour 12, other PM hours get +12.
  assign h24_from12 = (set_hours == H12_MAX) ? (set_pm ? H12_MAX : 5'd0)
                                             : (set_pm ? set_hours + H12_MAX : set_hours);

  hms_t tod_q, tod_d, sw_q, sw_d, snap_q, snap_d;
  logic sw_run_q, sw_run_d, lap_q, lap_d;
  logic is_sw;
  assign is_sw = (mode_s == MODE_SW);

  always_comb begin
    tod_d = tod_q;
    if (tod_load24)      tod_d = set_hms;
    else if (tod_load12) tod_d = '{h: h24_from12, m: set_mins, s: set_secs};
    else if (tick)       tod_d = hms_inc(tod_q);
  end

  always_comb begin
    sw_d     = sw_q;
    sw_run_d = sw_run_q;
    lap_d    = lap_q;
    snap_d   = snap_q;
    if (is_sw && load) begin
      sw_d     = '0;
      sw_run_d = 1'b0;
      lap_d    = 1'b0;
    end else begin
      if (tick && sw_run_q) sw_d = hms_inc(sw_q);
      if (is_sw && run_tgl) sw_run_d = ~sw_run_q;
      // Freeze captures the value shown up to now so the display never jumps.
      if (is_sw && lap && sw_run_q) begin
        lap_d  = ~lap_q;
        snap_d = sw_q;
      end
    end
  end

  // Timer channels
  hms_t               ch_time [NUM_TMR];
  logic [NUM_TMR-1:0] ch_run, ch_exp, ch_load, ch_tgl;

  always_comb begin
    ch_load = '0;
    ch_tgl  = '0;
    for (int i = 0; i < NUM_TMR; i++) begin
      if (mode_s == MODE_TMR && tmr_sel == SEL_W'(i)) begin
        ch_load[i] = load;
        ch_tgl[i]  = run_tgl;
      end
    end
  end

  for (genvar g = 0; g < NUM_TMR; g++) begin : g_ch
    tk_tmr_channel u_ch (
      .clk_i     (clk),
      .rst_ni    (reset),
      .tick_i    (tick),
      .load_i    (ch_load[g]),
      .run_tgl_i (ch_tgl[g]),
      .set_i     (set_hms),
      .time_o    (ch_time[g]),
      .running_o (ch_run[g]),
      .expired_o (ch_exp[g])
    );
  end

  // Display selection
  hms_t disp_t;
  logic disp_pm, disp_run;

  always_comb begin
    disp_t   = tod_q;
    disp_pm  = 1'b0;
    disp_run = 1'b1;
    case (mode_s)
      MODE_CLK12: begin
        if (tod_q.h == 5'd0)         disp_t.h = H12_MAX;
        else if (tod_q.h > H12_MAX)  disp_t.h = tod_q.h - H12_MAX;
        disp_pm = (tod_q.h >= H12_MAX);
      end
      MODE_SW: begin
        disp_t   = lap_q ? snap_q : sw_q;
        disp_run = sw_run_q;
      end
      MODE_TMR: begin
        disp_t   = '0;
        disp_run = 1'b0;
        for (int i = 0; i < NUM_TMR; i++) begin
          if (tmr_sel == SEL_W'(i)) begin
            disp_t   = ch_time[i];
            disp_run = ch_run[i];
          end
        end
      end
      default: ;
    endcase
  end

  hms_t               disp_q;
  logic               pm_q, running_q, tick_q;
  logic [NUM_TMR-1:0] expired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      tod_q     <= '0;
      sw_q      <= '0;
      snap_q    <= '0;
      sw_run_q  <= 1'b0;
      lap_q     <= 1'b0;
      disp_q    <= '0;
      pm_q      <= 1'b0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      expired_q <= '0;
    end else begin
      presc_q   <= presc_d;
      tod_q     <= tod_d;
      sw_q      <= sw_d;
      snap_q    <= snap_d;
      sw_run_q  <= sw_run_d;
      lap_q     <= lap_d;
      disp_q    <= disp_t;
      pm_q      <= disp_pm;
      running_q <= disp_run;
      tick_q    <= tick;
      expired_q <= ch_exp;
    end
  end

  assign hours_o   = disp_q.h;
  assign mins_o    = disp_q.m;
  assign secs_o    = disp_q.s;
  assign pm_o      = pm_q;
  assign running_o = running_q;
  assign expired_o = expired_q;
  assign tick_o    = tick_q;

endmodule
